// File: rtl/icache_direct_mapped_if.sv
// Fault type and the fetch-side request/response bundles shared by the
// instruction cache and whatever drives it.
package icache_pkg;
    typedef enum logic [1:0] {
        FAULT_NONE     = 2'd0,
        FAULT_ACCESS   = 2'd1,
        FAULT_PAGE     = 2'd2,
        FAULT_MISALIGN = 2'd3
    } fault_ty_e;
endpackage

interface cache_req_if;
    logic        valid;
    logic        ready;
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    modport cache (input valid, addr, wen, wdata, wmask, output ready);
    modport fetch (output valid, addr, wen, wdata, wmask, input ready);
endinterface

interface cache_resp_if;
    import icache_pkg::*;
    logic        valid;
    logic [31:0] rdata;
    logic        error;
    fault_ty_e   errty;
    modport cache (output valid, rdata, error, errty);
    modport fetch (input valid, rdata, error, errty);
endinterface

// File: rtl/icache_direct_mapped.sv
// Direct-mapped read-only instruction cache: one-cycle hits, stalling
// word-by-word line refill from lower memory, faults forwarded uncached.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int LINE_WORDS  = 4,
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    cache_req_if.cache  memreq,
    cache_resp_if.cache memresp,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_rdata,
    input  logic        mem_resp_error,
    input  fault_ty_e   mem_resp_errty
);
    localparam int WORD_BITS = $clog2(LINE_WORDS);
    localparam int OFF       = 2 + WORD_BITS;
    localparam int TAG       = 32 - INDEX_WIDTH - OFF;
    localparam int LINES     = 1 << INDEX_WIDTH;

    typedef enum logic [1:0] {IDLE, REFILL_REQ, REFILL_WAIT, RESP} state_e;

    state_e state, state_nxt;

    logic [TAG-1:0]              tag_mem  [LINES];
    logic [LINE_WORDS-1:0][31:0] data_mem [LINES];
    logic [LINES-1:0]            valid_bits;

    logic                        pending;
    logic [31:0]                 paddr;
    logic [TAG-1:0]              ptag;
    logic [INDEX_WIDTH-1:0]      pidx;
    logic [WORD_BITS-1:0]        pword;
    logic [INDEX_WIDTH-1:0]      aidx;
    logic [WORD_BITS-1:0]        aword;

    logic [TAG-1:0]              tag_q;
    logic [31:0]                 word_q;
    logic [LINE_WORDS-1:0][31:0] line_buf;
    logic [WORD_BITS-1:0]        cnt;
    logic                        err_q;
    fault_ty_e                   errty_q;
    logic                        drop_fill;

    logic hit, miss, ready, accept, last_word, fill_ok;

    assign ptag  = paddr[31:32-TAG];
    assign pidx  = paddr[OFF+INDEX_WIDTH-1:OFF];
    assign pword = paddr[OFF-1:2];
    assign aidx  = memreq.addr[OFF+INDEX_WIDTH-1:OFF];
    assign aword = memreq.addr[OFF-1:2];

    // Lookup result only means something for the request registered last cycle.
    assign hit       = (state == IDLE) & pending & valid_bits[pidx] & (tag_q == ptag);
    assign miss      = (state == IDLE) & pending & ~hit;
    assign ready     = (state == IDLE) & ~miss;
    assign accept    = memreq.valid & ready;
    assign last_word = (cnt == WORD_BITS'(LINE_WORDS - 1));
    assign fill_ok   = (state == RESP) & ~err_q & ~drop_fill;

    logic unused_ok;
    assign unused_ok = ^{memreq.wen, memreq.wdata, memreq.wmask, memreq.addr[1:0], paddr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:        if (miss) state_nxt = REFILL_REQ;
            REFILL_REQ:  if (mem_req_ready) state_nxt = REFILL_WAIT;
            REFILL_WAIT: begin
                if (mem_resp_valid) begin
                    if (mem_resp_error || last_word) state_nxt = RESP;
                    else                             state_nxt = REFILL_REQ;
                end
            end
            RESP:        state_nxt = IDLE;
            default:     state_nxt = IDLE;
        endcase
    end

    always_comb begin
        memreq.ready  = ready;
        memresp.valid = hit | (state == RESP);
        memresp.rdata = 32'd0;
        memresp.error = 1'b0;
        memresp.errty = FAULT_NONE;
        mem_req_valid = (state == REFILL_REQ);
        mem_req_addr  = 32'd0;
        if (hit) begin
            memresp.rdata = word_q;
        end else if (state == RESP) begin
            memresp.rdata = err_q ? 32'd0 : line_buf[pword];
            memresp.error = err_q;
            memresp.errty = err_q ? errty_q : FAULT_NONE;
        end
        if (state == REFILL_REQ) mem_req_addr = {ptag, pidx, cnt, 2'b00};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending    <= 1'b0;
            paddr      <= 32'd0;
            cnt        <= '0;
            err_q      <= 1'b0;
            errty_q    <= FAULT_NONE;
            drop_fill  <= 1'b0;
            valid_bits <= '0;
        end else begin
            if (accept) begin
                pending <= 1'b1;
                paddr   <= memreq.addr;
            end else if (hit || state == RESP) begin
                pending <= 1'b0;
            end

            if (miss) cnt <= '0;
            else if (state == REFILL_WAIT && mem_resp_valid && !mem_resp_error && !last_word)
                cnt <= cnt + WORD_BITS'(1);

            if (state == REFILL_WAIT && mem_resp_valid && mem_resp_error) begin
                err_q   <= 1'b1;
                errty_q <= mem_resp_errty;
            end else if (state == RESP) begin
                err_q   <= 1'b0;
            end

            // A flush while a line is in flight must keep that line from being validated.
            if (state == RESP)                drop_fill <= 1'b0;
            else if (flush && state != IDLE)  drop_fill <= 1'b1;

            if (flush)        valid_bits       <= '0;
            else if (fill_ok) valid_bits[pidx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q  <= tag_mem[aidx];
            word_q <= data_mem[aidx][aword];
        end
        if (state == REFILL_WAIT && mem_resp_valid)
            line_buf[cnt] <= mem_resp_rdata;
        if (fill_ok) begin
            tag_mem[pidx]  <= ptag;
            data_mem[pidx] <= line_buf;
        end
    end

endmodule
